// File: rtl/im_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : im_loader_pkg
// Description : Shared states and frame constants for the instruction-memory
//               loader.
// Revision    : 1.0
// ============================================================================
package im_loader_pkg;

    localparam logic [31:0] c_IM_BASE_ADDR = 32'h0000_3000;
    localparam int          c_LEN_BYTES    = 2;
    localparam int          c_WORD_BYTES   = 4;
    localparam int          c_CHK_BYTES    = 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CHK    = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/im_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : im_word_packer
// Description : Packs bytes MSB-first into 32-bit words and keeps the running
//               XOR checksum of every packed byte.
// Revision    : 1.0
// ============================================================================
module im_word_packer
    import im_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_byte_en,
    input  logic [7:0]  i_byte,
    output logic        o_last_byte,
    output logic        o_word_ready,
    output logic [31:0] o_word,
    output logic [7:0]  o_checksum
);

    localparam logic [1:0] c_LAST_IDX = 2'(c_WORD_BYTES - 1);

    logic [1:0]  r_byte_cnt;
    logic [23:0] r_shift;
    logic [31:0] r_word;
    logic        r_word_ready;
    logic [7:0]  r_checksum;

    assign o_last_byte  = i_byte_en && (r_byte_cnt == c_LAST_IDX);
    assign o_word_ready = r_word_ready;
    assign o_word       = r_word;
    assign o_checksum   = r_checksum;

    // The finished word is copied out so the shifter can take the next
    // word's first byte in the same cycle the write strobe is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_byte_cnt   <= 2'd0;
            r_shift      <= 24'd0;
            r_word       <= 32'd0;
            r_word_ready <= 1'b0;
            r_checksum   <= 8'd0;
        end else begin
            r_word_ready <= 1'b0;
            if (i_clear) begin
                r_byte_cnt <= 2'd0;
                r_shift    <= 24'd0;
                r_checksum <= 8'd0;
            end else if (i_byte_en) begin
                r_checksum <= r_checksum ^ i_byte;
                r_shift    <= {r_shift[15:0], i_byte};
                if (o_last_byte) begin
                    r_word       <= {r_shift, i_byte};
                    r_word_ready <= 1'b1;
                    r_byte_cnt   <= 2'd0;
                end else begin
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
// Module      : im_loader
// Description : Loads a length-prefixed, XOR-checked byte stream into the
//               instruction memory and holds the CPU until it is verified.
// Revision    : 1.0
// ============================================================================
module im_loader
    import im_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int ADDR_W      = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_waddr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_len_hi;
    logic [15:0]     r_len;
    logic [ADDR_W:0] r_words_loaded;

    logic        w_xfer;
    logic        w_clear;
    logic        w_byte_en;
    logic        w_last_byte;
    logic        w_last_word;
    logic        w_word_ready;
    logic [15:0] w_len;
    logic [7:0]  w_checksum;

    assign rx_ready     = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                          (r_state == S_DATA)   || (r_state == S_CHK);
    assign w_xfer       = rx_valid && rx_ready;
    assign w_byte_en    = w_xfer && (r_state == S_DATA);
    assign w_len        = {r_len_hi, rx_data};
    // Word index of the byte in flight equals words already written, since
    // each write lands three cycles before the next word can complete.
    assign w_last_word  = (32'(r_words_loaded) + 32'd1) == {16'd0, r_len};

    assign done         = (r_state == S_DONE);
    assign err          = (r_state == S_ERR);
    assign cpu_hold     = (r_state != S_DONE);
    assign im_we        = w_word_ready;
    assign im_waddr     = r_words_loaded[ADDR_W-1:0];
    assign words_loaded = r_words_loaded;

    im_word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_clear),
        .i_byte_en    (w_byte_en),
        .i_byte       (rx_data),
        .o_last_byte  (w_last_byte),
        .o_word_ready (w_word_ready),
        .o_word       (im_wdata),
        .o_checksum   (w_checksum)
    );

    always_comb begin
        w_next  = r_state;
        w_clear = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    w_next  = S_LEN_HI;
                    w_clear = 1'b1;
                end
            end
            S_LEN_HI: begin
                if (w_xfer) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_xfer) begin
                    if ({16'd0, w_len} > 32'(DEPTH_WORDS)) w_next = S_ERR;
                    else if (w_len == 16'd0)              w_next = S_CHK;
                    else                                   w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_last_byte && w_last_word) w_next = S_CHK;
            end
            S_CHK: begin
                if (w_xfer) w_next = (rx_data == w_checksum) ? S_DONE : S_ERR;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_len_hi       <= 8'd0;
            r_len          <= 16'd0;
            r_words_loaded <= '0;
        end else begin
            r_state <= w_next;
            if (w_xfer && (r_state == S_LEN_HI)) r_len_hi <= rx_data;
            if (w_xfer && (r_state == S_LEN_LO)) r_len    <= w_len;
            if (w_clear)           r_words_loaded <= '0;
            else if (w_word_ready) r_words_loaded <= r_words_loaded + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_im_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_im_loader
// Description : Self-checking bench for im_loader: table vectors, corner
//               sequences and randomized frames against a frame-level model.
// Revision    : 1.0
// ============================================================================
module tb_im_loader;

    localparam int DEPTH = 4096;
    localparam int AW    = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_ready;
    logic          im_we;
    logic [AW-1:0] im_waddr;
    logic [31:0]   im_wdata;
    logic          cpu_hold;
    logic          done;
    logic          err;
    logic [AW:0]   words_loaded;

    im_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .im_we        (im_we),
        .im_waddr     (im_waddr),
        .im_wdata     (im_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int stalls   = 0;

    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];
    logic [31:0]   words_q[$];
    logic [7:0]    frame_q[$];

    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            wr_addr_q.push_back(im_waddr);
            wr_data_q.push_back(im_wdata);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [7:0] ref_chk();
        logic [7:0] x;
        logic [31:0] w;
        x = 8'd0;
        foreach (words_q[i]) begin
            w = words_q[i];
            x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        end
        return x;
    endfunction

    task automatic build_frame(input logic [7:0] chk);
        logic [15:0] n16;
        logic [31:0] w;
        n16 = 16'(words_q.size());
        frame_q.delete();
        frame_q.push_back(n16[15:8]);
        frame_q.push_back(n16[7:0]);
        foreach (words_q[i]) begin
            w = words_q[i];
            frame_q.push_back(w[31:24]);
            frame_q.push_back(w[23:16]);
            frame_q.push_back(w[15:8]);
            frame_q.push_back(w[7:0]);
        end
        frame_q.push_back(chk);
    endtask

    // Sends the first nbytes of frame_q; max_gap>0 inserts 1..max_gap idle
    // cycles before every byte. start is raised alongside byte start_idx.
    task automatic send(input int nbytes, input int max_gap, input int start_idx);
        int  g;
        int  waited;
        bit  ok;
        for (int i = 0; i < nbytes && i < frame_q.size(); i++) begin
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 1)) : 0;
            repeat (g) tick();
            rx_valid = 1'b1;
            rx_data  = frame_q[i];
            if (i == start_idx) start = 1'b1;
            waited = 0;
            ok = 1'b0;
            while (!ok) begin
                @(negedge clk);
                if (rx_ready) ok = 1'b1;
                else stalls++;
                @(posedge clk);
                #1;
                start = 1'b0;
                if (!ok) begin
                    waited++;
                    if (waited > 50) begin
                        check("rx_timeout", 32'd0, 32'd1);
                        rx_valid = 1'b0;
                        return;
                    end
                end
            end
            rx_valid = 1'b0;
        end
    endtask

    task automatic expect_writes();
        check("wr_count", wr_data_q.size(), words_q.size());
        for (int i = 0; i < words_q.size() && i < wr_data_q.size(); i++) begin
            check("wr_addr", 32'(wr_addr_q[i]), i);
            check("wr_data", wr_data_q[i], words_q[i]);
        end
    endtask

    task automatic run_load(input logic [7:0] chk, input int gap, input bit do_start, input int start_idx);
        wr_addr_q.delete();
        wr_data_q.delete();
        stalls = 0;
        if (do_start) pulse_start();
        build_frame(chk);
        send(frame_q.size(), gap, start_idx);
        repeat (2) tick();
    endtask

    task automatic check_final(input logic exp_done, input int exp_wl);
        check("done", done, exp_done);
        check("err", err, !exp_done);
        check("cpu_hold", cpu_hold, !exp_done);
        check("words_loaded", 32'(words_loaded), exp_wl);
        check("rx_ready_idle", rx_ready, 1'b0);
        expect_writes();
    endtask

    typedef struct {
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [7:0]  chk;
        int          gap;
        logic        exp_done;
        int          exp_wl;
    } vec_t;

    vec_t vt[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] good;
        logic [7:0] chk;
        bit         corrupt;
        int         n;

        // Bytes of 3C010001 and 34210002 XOR to 0x2B.
        vt[0] = '{2, 32'h3C010001, 32'h34210002, 8'h2B, 0, 1'b1, 2};
        vt[1] = '{2, 32'h3C010001, 32'h34210002, 8'h2B, 3, 1'b1, 2};
        vt[2] = '{1, 32'hFFFFFFFF, 32'h0,        8'h01, 0, 1'b0, 1};
        vt[3] = '{1, 32'hFFFFFFFF, 32'h0,        8'h00, 2, 1'b1, 1};
        vt[4] = '{0, 32'h0,        32'h0,        8'h00, 0, 1'b1, 0};
        vt[5] = '{0, 32'h0,        32'h0,        8'h5A, 1, 1'b0, 0};
        vt[6] = '{2, 32'h3C010001, 32'h34210002, 8'h0B, 0, 1'b0, 2};

        repeat (3) tick();
        check("rst_rx_ready", rx_ready, 1'b0);
        check("rst_im_we", im_we, 1'b0);
        check("rst_im_waddr", 32'(im_waddr), 32'd0);
        check("rst_im_wdata", im_wdata, 32'd0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_words_loaded", 32'(words_loaded), 32'd0);
        check("rst_cpu_hold", cpu_hold, 1'b1);
        reset = 1'b1;
        repeat (2) tick();

        foreach (vt[v]) begin
            words_q.delete();
            if (vt[v].n > 0) words_q.push_back(vt[v].w0);
            if (vt[v].n > 1) words_q.push_back(vt[v].w1);
            run_load(vt[v].chk, vt[v].gap, 1'b1, -1);
            check_final(vt[v].exp_done, vt[v].exp_wl);
            if (vt[v].gap == 0) check("stalls", stalls, 0);
        end

        // Oversize length: rejected right after the length bytes.
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        frame_q.delete();
        frame_q.push_back(8'h10);
        frame_q.push_back(8'h01);
        send(2, 0, -1);
        check("big_err", err, 1'b1);
        check("big_done", done, 1'b0);
        check("big_rx_ready", rx_ready, 1'b0);
        repeat (3) tick();
        check("big_writes", wr_data_q.size(), 0);

        // start during DATA is ignored.
        words_q.delete();
        repeat (3) words_q.push_back($urandom);
        run_load(ref_chk(), 0, 1'b1, 5);
        check_final(1'b1, 3);

        // start in DONE restarts; the hold returns the next cycle.
        pulse_start();
        check("restart_hold", cpu_hold, 1'b1);
        check("restart_done", done, 1'b0);
        check("restart_rx_ready", rx_ready, 1'b1);
        words_q.delete();
        repeat (2) words_q.push_back($urandom);
        run_load(ref_chk(), 0, 1'b0, -1);
        check_final(1'b1, 2);

        // Reset after the 2nd byte of word 1.
        words_q.delete();
        repeat (2) words_q.push_back($urandom);
        build_frame(ref_chk());
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        send(8, 0, -1);
        #2 reset = 1'b0;
        #1;
        check("arst_rx_ready", rx_ready, 1'b0);
        check("arst_im_we", im_we, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_cpu_hold", cpu_hold, 1'b1);
        tick();
        reset = 1'b1;
        check("arst_writes", wr_data_q.size(), 1);
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        repeat (10) tick();
        rx_valid = 1'b0;
        check("idle_writes", wr_data_q.size(), 1);
        check("idle_rx_ready", rx_ready, 1'b0);
        check("idle_words_loaded", 32'(words_loaded), 32'd0);

        // Reset during the write cycle of word 0 and while in DONE.
        words_q.delete();
        words_q.push_back(32'h1234_5678);
        build_frame(ref_chk());
        pulse_start();
        send(6, 0, -1);
        check("wcyc_im_we", im_we, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("wcyc_arst_im_we", im_we, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        run_load(ref_chk(), 0, 1'b1, -1);
        check("pre_rst_done", done, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("done_arst", done, 1'b0);
        check("done_arst_hold", cpu_hold, 1'b1);
        tick();
        reset = 1'b1;
        tick();

        // Randomized frames against the frame-level model.
        for (int it = 0; it < 20; it++) begin
            n = int'($urandom_range(6, 0));
            words_q.delete();
            repeat (n) words_q.push_back($urandom);
            good    = ref_chk();
            corrupt = ($urandom_range(3, 0) == 0);
            chk     = corrupt ? (good ^ 8'($urandom_range(255, 1))) : good;
            run_load(chk, int'($urandom_range(2, 0)), 1'b1, -1);
            check_final(!corrupt, n);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
